dmem_arbiter: RTL

Two-port arbiter and sequencer in front of `data_memory`. It shares the single data memory between requester 0 (core load/store unit) and requester 1 (debug/DMA port). Arbitration is round-robin, with one transaction outstanding at a time. Each requester has valid/ready request and response channels. Addresses, store types and data pass through unmodified; `data_memory` itself handles byte-lane rotation for unaligned accesses.

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and sequencer in front of data_memory.
// One transaction is outstanding at a time; responses return only to the owner.
module dmem_arbiter #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic [DATA_W-1:0] r0_req_wdata,
  input  logic              r0_req_we,
  input  logic [1:0]        r0_req_type,
  output logic              r0_rsp_valid,
  output logic [DATA_W-1:0] r0_rsp_rdata,
  input  logic              r0_rsp_ready,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [ADDR_W-1:0] r1_req_addr,
  input  logic [DATA_W-1:0] r1_req_wdata,
  input  logic              r1_req_we,
  input  logic [1:0]        r1_req_type,
  output logic              r1_rsp_valid,
  output logic [DATA_W-1:0] r1_rsp_rdata,
  input  logic              r1_rsp_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_write_enable,
  output logic [1:0]        mem_store_type,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_grant;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_we;
  logic [1:0]          r_type;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_mem_we;
  logic [1:0]          r_rsp_valid;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                w_grant;
  logic                w_hs;
  logic                w_rsp_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Arbitration, request handshake and next-state decode
  always_comb begin
    w_next_state = r_state;
    w_hs         = 1'b0;
    r0_req_ready = 1'b0;
    r1_req_ready = 1'b0;
    w_grant      = (r0_req_valid & r1_req_valid) ? ~r_last_grant : r1_req_valid;
    w_rsp_fire   = r_owner ? (r_rsp_valid[1] & r1_rsp_ready)
                           : (r_rsp_valid[0] & r0_rsp_ready);
    case (r_state)
      IDLE: begin
        if ((r0_req_valid | r1_req_valid) & rst_n) begin
          w_hs         = 1'b1;
          r0_req_ready = ~w_grant;
          r1_req_ready = w_grant;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (r_we || (r_cnt == '0)) w_next_state = RESP;
      end
      RESP: begin
        if (w_rsp_fire) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Capture, latency counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_type       <= 2'b00;
      r_cnt        <= '0;
      r_mem_we     <= 1'b0;
      r_rsp_valid  <= 2'b00;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_hs) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_addr       <= w_grant ? r1_req_addr  : r0_req_addr;
        r_wdata      <= w_grant ? r1_req_wdata : r0_req_wdata;
        r_we         <= w_grant ? r1_req_we    : r0_req_we;
        r_type       <= w_grant ? r1_req_type  : r0_req_type;
        r_mem_we     <= w_grant ? r1_req_we    : r0_req_we;
        r_cnt        <= CNT_W'(MEM_LATENCY - 1);
      end
      if ((r_state == ISSUE) && !r_we && (r_cnt != '0)) r_cnt <= r_cnt - CNT_W'(1);
      if ((r_state == ISSUE) && (w_next_state == RESP)) begin
        if (r_owner) begin
          r_rsp_valid[1] <= 1'b1;
          r_rdata1       <= r_we ? '0 : mem_read_data;
        end else begin
          r_rsp_valid[0] <= 1'b1;
          r_rdata0       <= r_we ? '0 : mem_read_data;
        end
      end
      if ((r_state == RESP) && w_rsp_fire) r_rsp_valid <= 2'b00;
    end
  end

  assign r0_rsp_valid     = r_rsp_valid[0];
  assign r1_rsp_valid     = r_rsp_valid[1];
  assign r0_rsp_rdata     = r_rdata0;
  assign r1_rsp_rdata     = r_rdata1;
  assign mem_address      = r_addr;
  assign mem_data         = r_wdata;
  assign mem_write_enable = r_mem_we;
  assign mem_store_type   = r_type;

endmodule
